buffer2axis: RTL
================

BUFFER2AXIS -- requirements
Module: buffer2axis

Interface
REQ-001 Parameter DWIDTH, default 32, pixel width in bits (AXIS TDATA width).
REQ-002 Parameter WIDTH, default 8, cells per row (bits of in_data).
REQ-003 Parameter HEIGHT, default 8, rows per frame; TLAST marks the end of a frame.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 alive_color  input  DWIDTH  pixel value emitted for a cell bit of 1.
REQ-008 dead_color  input  DWIDTH  pixel value emitted for a cell bit of 0.
REQ-009 in_data  input  WIDTH  one row of cell states from the conware computation; bit i is pixel i.
REQ-010 in_valid  input  1  in_data holds a valid row.
REQ-011 in_ready  output  1  block can accept a row.
REQ-012 M_AXIS_TDATA  output  DWIDTH  pixel color.
REQ-013 M_AXIS_TVALID  output  1  pixel valid.
REQ-014 M_AXIS_TREADY  input  1  downstream accepts the pixel.
REQ-015 M_AXIS_TLAST  output  1  last pixel of the frame.

Function
REQ-016 The FSM shall have two states: IDLE and SEND.
REQ-017 IDLE: in_ready=1 and M_AXIS_TVALID=0; in_valid=1 shall capture in_data, alive_color and dead_color into internal registers, clear pix_cnt, and move to SEND.
REQ-018 The first pixel of a captured row shall appear on M_AXIS_TVALID/TDATA in the cycle after the capture (latency 1).
REQ-019 SEND: in_ready=0 and M_AXIS_TVALID=1; TDATA = captured alive color if row bit pix_cnt is 1, else the captured dead color.
REQ-020 Pixels shall be emitted in order bit 0 to bit WIDTH-1.
REQ-021 A beat completes only when TVALID and TREADY are both 1; pix_cnt shall then increment.
REQ-022 While TVALID=1 and TREADY=0, TDATA, TLAST and the internal state shall hold unchanged; changes on alive_color, dead_color or in_data shall not affect the row in flight.
REQ-023 On completion of the beat with pix_cnt=WIDTH-1: pix_cnt clears to 0, row_cnt advances, and the FSM returns to IDLE. This gives one idle cycle between consecutive rows.
REQ-024 row_cnt shall count 0..HEIGHT-1 and wrap to 0 after the last row of the frame.
REQ-025 M_AXIS_TLAST shall be 1 only while pix_cnt=WIDTH-1, row_cnt=HEIGHT-1 and TVALID=1; otherwise it shall be 0.
REQ-026 in_data presented while in_ready=0 shall be ignored and never queued.
REQ-027 Counters shall be sized as clog2(WIDTH) and clog2(HEIGHT) bits, minimum 1 bit; WIDTH=1 and HEIGHT=1 shall be legal.
REQ-028 M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST and in_ready shall be driven directly from registers or FSM state, with no combinational path from M_AXIS_TREADY or in_valid.

Reset
REQ-029 When rst=1 at a clock edge: state=IDLE, pix_cnt=0, row_cnt=0, captured row and colors=0.
REQ-030 During reset and in the first cycle after it: in_ready=1, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0.
REQ-031 A reset asserted mid-row or mid-frame shall discard the partial row and frame. TVALID shall be 0 from the following cycle, and the next frame shall start at row 0.

Structure
REQ-032 The FSM state encoding (IDLE, SEND) and default parameter values shall live in a shared package conware_pkg, which axis2buffer also uses.
REQ-033 The color-select mux shall be a sub-module cell2color (bit, alive, dead -> pixel), reusable by the other conware stream blocks.

Verification
REQ-034 Default parameters, TREADY=1, alive=FFFFFFFF, dead=00000000, in_data=8'b1010_0101 -> TDATA FFFFFFFF,0,FFFFFFFF,0,0,FFFFFFFF,0,FFFFFFFF on 8 consecutive cycles starting 1 cycle after capture; TLAST=0 throughout.
REQ-035 Stream 8 rows with TREADY=1 -> 64 beats, TLAST=1 only on beat 64; a 9th row starts a new frame with TLAST on its row-8 beat.
REQ-036 Backpressure: TREADY low for 3 cycles on pixel 2 -> TDATA and TLAST stable for those 3 cycles, no pixel lost or duplicated, in_ready=0 throughout.
REQ-037 Change alive_color to 12345678 mid-row -> the remaining pixels of that row still use the captured value; the next row uses 12345678.
REQ-038 Assert rst on pixel 4 of row 5 -> TVALID=0 the next cycle, in_ready=1, and the next row emits TLAST only after 8 full rows.
REQ-039 in_valid pulsed during SEND -> ignored; output sequence identical to the no-pulse case.

Source files
------------

// File: rtl/conware_pkg.sv
// Shared definitions for the conware stream blocks: FSM states, default
// geometry and a counter-width helper.
package conware_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEFAULT_DWIDTH = 32;
    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_HEIGHT = 8;

    // A counter over n items needs clog2(n) bits, but never fewer than one.
    function automatic int cntBits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer2axis_if.sv
// AXI4-Stream master bus carrying rendered pixels downstream.
interface buffer2axis_if
    import conware_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH
);

    logic [DWIDTH-1:0] TDATA;
    logic              TVALID;
    logic              TREADY;
    logic              TLAST;

    modport master (
        output TDATA,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        input  TLAST,
        output TREADY
    );

endinterface

// File: rtl/cell2color.sv
// Maps one cell state to its pixel color; shared by the conware stream blocks.
module cell2color
    import conware_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH
) (
    input  logic              i_bit,
    input  logic [DWIDTH-1:0] i_alive,
    input  logic [DWIDTH-1:0] i_dead,
    output logic [DWIDTH-1:0] o_pixel
);

    assign o_pixel = i_bit ? i_alive : i_dead;

endmodule

// File: rtl/buffer2axis.sv
// Serialises one row of cell states into AXI4-Stream pixels, one beat per
// cell, with TLAST on the final pixel of every HEIGHT-row frame.
module buffer2axis
    import conware_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] alive_color,
    input  logic [DWIDTH-1:0] dead_color,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    buffer2axis_if.master     M_AXIS
);

    localparam int PW = cntBits(WIDTH);
    localparam int RW = cntBits(HEIGHT);
    localparam logic [PW-1:0] LAST_PIX = PW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic               w_beat;
    logic               w_capture;
    logic [PW-1:0]      r_pixCnt;
    logic [RW-1:0]      r_rowCnt;
    logic [WIDTH-1:0]   r_row;
    logic [DWIDTH-1:0]  r_alive;
    logic [DWIDTH-1:0]  r_dead;
    logic [DWIDTH-1:0]  w_pixel;

    always_comb begin
        w_stateNext = r_state;
        w_beat      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_capture   = 1'b1;
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                if (M_AXIS.TREADY) begin
                    w_beat = 1'b1;
                    if (r_pixCnt == LAST_PIX) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Row and colors are frozen at capture so input changes never reach a row in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixCnt <= '0;
            r_rowCnt <= '0;
            r_row    <= '0;
            r_alive  <= '0;
            r_dead   <= '0;
        end else if (w_capture) begin
            r_pixCnt <= '0;
            r_row    <= in_data;
            r_alive  <= alive_color;
            r_dead   <= dead_color;
        end else if (w_beat) begin
            if (r_pixCnt == LAST_PIX) begin
                r_pixCnt <= '0;
                r_rowCnt <= (r_rowCnt == LAST_ROW) ? '0 : r_rowCnt + 1'b1;
            end else begin
                r_pixCnt <= r_pixCnt + 1'b1;
            end
        end
    end

    cell2color #(
        .DWIDTH (DWIDTH)
    ) u_cell2color (
        .i_bit   (r_row[r_pixCnt]),
        .i_alive (r_alive),
        .i_dead  (r_dead),
        .o_pixel (w_pixel)
    );

    // Outputs depend only on registered state, never on TREADY or in_valid.
    assign in_ready      = (r_state == IDLE);
    assign M_AXIS.TVALID = (r_state == SEND);
    assign M_AXIS.TDATA  = (r_state == SEND) ? w_pixel : '0;
    assign M_AXIS.TLAST  = (r_state == SEND) && (r_pixCnt == LAST_PIX) && (r_rowCnt == LAST_ROW);

endmodule
